mem_req_queue: RTL and testbench

- Front end of the data-memory path. Buffers load/store requests from the EX/memory stage in a small FIFO.
- Issues the requests one at a time to the dcache using its command/addr/data/size interface, and waits for the dcache `finished` indication on each.
- Returns load results to the pipeline, aligned and sign/zero-extended, tagged with the requester's ROB/LSQ tag. Store completions are returned through the same port.

---
 rtl/mem_req_queue.sv | 208 ++++++++++++++++++++
 tb/tb_mem_req_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// Purpose: buffers EX-stage load/store requests and issues them one at a time to the dcache.
// Latency: a request pushed at edge N issues at edge N+1 at the earliest; completion pulses the cycle after finished.
// Backpressure: in_ready drops while the FIFO holds DEPTH entries (no same-cycle pop bypass); the dcache paces issue via finished.
module mem_req_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_command,
    input  logic [XLEN-1:0]  in_addr,
    input  logic [63:0]      in_data,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             squash,
    output logic [1:0]       proc2Dcache_command,
    output logic [XLEN-1:0]  proc2Dcache_addr,
    output logic [63:0]      proc2Dcache_data,
    output logic [1:0]       proc2Dcache_size,
    input  logic [63:0]      Dcache_data_out,
    input  logic             Dcache_valid_out,
    input  logic             finished,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_data,
    output logic             out_is_store,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef struct packed {
        logic [1:0]       command;
        logic [XLEN-1:0]  addr;
        logic [63:0]      data;
        logic [1:0]       size;
        logic             is_unsigned;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    req_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    state_t state;
    state_t state_nxt;

    // Issue registers: a private copy of the head entry, so a squash can
    // recycle FIFO slots while the dcache is still working on this request.
    req_t iss;
    logic iss_squashed;

    logic       push;
    logic       start;
    logic       complete;
    logic       deliver;
    logic [63:0] raw;
    logic [63:0] ext;
    logic        sgn;
    logic [XLEN-1:0] load_val;
    logic        unused_sink;

    req_t req_in;
    assign req_in = '{command:     in_command,
                      addr:        in_addr,
                      data:        in_data,
                      size:        in_size,
                      is_unsigned: in_unsigned,
                      tag:         in_tag};

    // Full FIFO stays not-ready even if the head pops this cycle.
    assign in_ready = (count != FULL_CNT);

    // A push coinciding with squash belongs to the squashed path and is dropped.
    assign push     = in_valid && in_ready && (in_command != CMD_NONE) && !squash;
    // Squash in IDLE wins over issuing the head.
    assign start    = (state == IDLE) && (count != '0) && !squash;
    assign complete = (state == ISSUE) && finished;
    // A squashed request still completes at the dcache but has already left
    // the FIFO (tail was pulled back to head), so it neither pops nor reports.
    assign deliver  = complete && !iss_squashed && !squash;

    // FIFO storage write; contents need no reset because count guards them.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[tail] <= req_in;
        end
    end

    // Pointer and occupancy bookkeeping, including squash flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            tail  <= head;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (deliver) begin
                head <= head + 1'b1;
            end
            case ({push, deliver})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: IDLE -> ISSUE on a queued entry, ISSUE -> GAP on finished, GAP -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = ISSUE;
            ISSUE:   if (finished) state_nxt = GAP;
            GAP:                   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // FSM outputs: command is only asserted in ISSUE so the dcache always sees a NONE between requests.
    always_comb begin
        proc2Dcache_command = CMD_NONE;
        if (state == ISSUE) begin
            proc2Dcache_command = iss.command;
        end
        empty = (count == '0) && (state == IDLE);
    end

    assign proc2Dcache_addr = iss.addr;
    assign proc2Dcache_data = iss.data;
    assign proc2Dcache_size = iss.size;

    // Latch the head into the issue registers and remember any squash seen during ISSUE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            iss          <= '0;
            iss_squashed <= 1'b0;
        end else if (start) begin
            iss          <= fifo_mem[head];
            iss_squashed <= 1'b0;
        end else if ((state == ISSUE) && squash) begin
            iss_squashed <= 1'b1;
        end
    end

    // Load alignment and extension from the 8-byte line returned with finished.
    always_comb begin
        raw = Dcache_data_out >> {iss.addr[2:0], 3'b000};
        sgn = !iss.is_unsigned;
        ext = raw;
        case (iss.size)
            2'd0:    ext = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    ext = {{32{sgn & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
        load_val = ext[XLEN-1:0];
    end

    // Completion port: one-cycle pulse; payload holds between pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_tag      <= '0;
            out_data     <= '0;
            out_is_store <= 1'b0;
        end else begin
            out_valid <= deliver;
            if (deliver) begin
                out_tag      <= iss.tag;
                out_is_store <= (iss.command == CMD_STORE);
                out_data     <= (iss.command == CMD_STORE) ? '0 : load_val;
            end
        end
    end

    // finished alone marks completion; the data-valid strobe carries no extra information here.
    assign unused_sink = ^{Dcache_valid_out, ext};

endmodule

// File: tb/tb_mem_req_queue.sv
// Purpose: self-checking bench for mem_req_queue: vector table through a dcache model plus corner sequences.
// Latency: completions are matched against a scoreboard in order of issue.
// Backpressure: stimulus waits on in_ready with a bounded cycle budget.
module tb_mem_req_queue;

    localparam int TAG_W = 5;
    localparam int XLEN  = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_command = 2'd0;
    logic [XLEN-1:0]  in_addr = '0;
    logic [63:0]      in_data = '0;
    logic [1:0]       in_size = 2'd0;
    logic             in_unsigned = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             squash = 1'b0;
    logic [1:0]       proc2Dcache_command;
    logic [XLEN-1:0]  proc2Dcache_addr;
    logic [63:0]      proc2Dcache_data;
    logic [1:0]       proc2Dcache_size;
    logic [63:0]      Dcache_data_out = '0;
    logic             Dcache_valid_out = 1'b0;
    logic             finished = 1'b0;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_data;
    logic             out_is_store;
    logic             empty;

    mem_req_queue #(.DEPTH(4), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock               (clock),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_command          (in_command),
        .in_addr             (in_addr),
        .in_data             (in_data),
        .in_size             (in_size),
        .in_unsigned         (in_unsigned),
        .in_tag              (in_tag),
        .squash              (squash),
        .proc2Dcache_command (proc2Dcache_command),
        .proc2Dcache_addr    (proc2Dcache_addr),
        .proc2Dcache_data    (proc2Dcache_data),
        .proc2Dcache_size    (proc2Dcache_size),
        .Dcache_data_out     (Dcache_data_out),
        .Dcache_valid_out    (Dcache_valid_out),
        .finished            (finished),
        .out_valid           (out_valid),
        .out_tag             (out_tag),
        .out_data            (out_data),
        .out_is_store        (out_is_store),
        .empty               (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  tag;
        logic [63:0] line;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        st;
    } exp_t;

    vec_t        vt [10];
    exp_t        exp_q [$];
    logic [63:0] line_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        auto_dc = 1'b0;
    int          wcnt = 0;
    int          wtarget = 1;
    logic        gap_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Sampled at negedge: NONE after every completion, and completions in order.
    task automatic monitor();
        exp_t e;
        if (gap_pending) check("gap_none", 64'(proc2Dcache_command), 64'd0);
        gap_pending = finished && (proc2Dcache_command != 2'd0);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                fail_now($sformatf("unexpected_completion tag=%0d data=%h", out_tag, out_data));
            end else begin
                e = exp_q.pop_front();
                check("completion", 64'({out_tag, out_data, out_is_store}), 64'(e));
            end
        end
    endtask

    // Dcache model: finishes each request after 1..3 cycles with the queued line.
    task automatic dc_step();
        finished = 1'b0;
        Dcache_valid_out = 1'b0;
        if (proc2Dcache_command != 2'd0) begin
            wcnt++;
            if (wcnt >= wtarget) begin
                if (line_q.size() == 0) begin
                    fail_now("dcache_model_no_line");
                end else begin
                    Dcache_data_out = line_q.pop_front();
                end
                finished = 1'b1;
                Dcache_valid_out = 1'b1;
                wcnt = 0;
                wtarget = $urandom_range(1, 3);
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        if (auto_dc) dc_step();
    endtask

    task automatic drive_req(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                             input logic [1:0] size, input logic uns, input logic [4:0] tag);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) fail_now("in_ready_timeout");
        in_valid    = 1'b1;
        in_command  = cmd;
        in_addr     = addr;
        in_data     = data;
        in_size     = size;
        in_unsigned = uns;
        in_tag      = tag;
        tick();
        in_valid    = 1'b0;
        in_command  = 2'd0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || !empty) && guard < 300) begin
            tick();
            guard++;
        end
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({name, "_empty"}, 64'(empty), 64'd1);
    endtask

    initial begin
        exp_t e;

        vt[0] = '{2'd2, 32'h10, 64'h1122334455667788, 2'd3, 1'b0, 5'd1,  64'h0,                32'h0};
        vt[1] = '{2'd1, 32'h10, 64'h0,                2'd3, 1'b1, 5'd2,  64'h1122334455667788, 32'h55667788};
        vt[2] = '{2'd1, 32'h11, 64'h0,                2'd0, 1'b0, 5'd3,  64'h000000000000F000, 32'hFFFFFFF0};
        vt[3] = '{2'd1, 32'h11, 64'h0,                2'd0, 1'b1, 5'd4,  64'h000000000000F000, 32'h000000F0};
        vt[4] = '{2'd1, 32'h14, 64'h0,                2'd2, 1'b0, 5'd5,  64'hDEADBEEF01234567, 32'hDEADBEEF};
        vt[5] = '{2'd1, 32'h12, 64'h0,                2'd1, 1'b0, 5'd6,  64'h0000000080010000, 32'hFFFF8001};
        vt[6] = '{2'd1, 32'h16, 64'h0,                2'd1, 1'b1, 5'd7,  64'hABCD000000000000, 32'h0000ABCD};
        vt[7] = '{2'd1, 32'h17, 64'h0,                2'd0, 1'b0, 5'd8,  64'h7F00000000000000, 32'h0000007F};
        vt[8] = '{2'd1, 32'h10, 64'h0,                2'd2, 1'b0, 5'd9,  64'h0000000080000000, 32'h80000000};
        vt[9] = '{2'd2, 32'h18, 64'h00000000000000AB, 2'd0, 1'b0, 5'd10, 64'h0,                32'h0};

        // Reset values
        repeat (3) tick();
        check("reset_state",
              64'({proc2Dcache_command, in_ready, empty, out_valid, out_tag, out_data, out_is_store}),
              64'({2'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0}));
        reset = 1'b1;
        tick();

        // Table-driven vectors through the dcache model
        auto_dc = 1'b1;
        wtarget = $urandom_range(1, 3);
        for (int i = 0; i < 10; i++) begin
            e.tag  = vt[i].tag;
            e.data = vt[i].exp_data;
            e.st   = (vt[i].cmd == 2'd2);
            exp_q.push_back(e);
            line_q.push_back(vt[i].line);
            drive_req(vt[i].cmd, vt[i].addr, vt[i].data, vt[i].size, vt[i].uns, vt[i].tag);
        end
        wait_drain("table");

        // Command 0 is never queued
        in_valid = 1'b1;
        in_command = 2'd0;
        in_tag = 5'd30;
        tick();
        in_valid = 1'b0;
        tick();
        check("cmd0_ignored", 64'(empty), 64'd1);

        // Full FIFO with the dcache stalled
        auto_dc = 1'b0;
        finished = 1'b0;
        for (int t = 0; t < 4; t++) begin
            e.tag  = 5'(t);
            e.data = 32'h10000000 + 32'(t);
            e.st   = 1'b0;
            exp_q.push_back(e);
            line_q.push_back({32'h0, 32'h10000000 + 32'(t)});
            drive_req(2'd1, 32'h10, 64'h0, 2'd2, 1'b0, 5'(t));
        end
        check("full_not_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_command = 2'd1;
        in_tag = 5'd9;
        tick();
        in_valid = 1'b0;
        in_command = 2'd0;
        check("full_fifth_rejected", 64'(in_ready), 64'd0);
        check("full_head_issued", 64'(proc2Dcache_command), 64'd1);
        finished = 1'b1;
        Dcache_valid_out = 1'b1;
        Dcache_data_out = line_q.pop_front();
        tick();
        finished = 1'b0;
        Dcache_valid_out = 1'b0;
        check("ready_after_pop", 64'(in_ready), 64'd1);
        wcnt = 0;
        auto_dc = 1'b1;
        wait_drain("full");

        // Squash with head in ISSUE and two more queued
        auto_dc = 1'b0;
        finished = 1'b0;
        drive_req(2'd1, 32'h20, 64'h0, 2'd2, 1'b0, 5'd20);
        drive_req(2'd1, 32'h24, 64'h0, 2'd2, 1'b0, 5'd21);
        drive_req(2'd2, 32'h28, 64'h5, 2'd2, 1'b0, 5'd22);
        check("squash_head_issued", 64'(proc2Dcache_command), 64'd1);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        check("squash_held_issue", 64'({proc2Dcache_command, in_ready, empty}), 64'({2'd1, 1'b1, 1'b0}));
        finished = 1'b1;
        Dcache_data_out = 64'hFFFFFFFFFFFFFFFF;
        tick();
        finished = 1'b0;
        tick();
        check("squash_empty_after_gap", 64'(empty), 64'd1);
        repeat (3) tick();
        check("squash_no_reissue", 64'({proc2Dcache_command, empty}), 64'({2'd0, 1'b1}));

        // Reset while a request is in ISSUE
        drive_req(2'd1, 32'h30, 64'h0, 2'd2, 1'b0, 5'd7);
        tick();
        check("rst_pre_issue", 64'(proc2Dcache_command), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_mid_issue", 64'({proc2Dcache_command, in_ready, empty, out_valid}),
              64'({2'd0, 1'b1, 1'b1, 1'b0}));
        finished = 1'b1;
        tick();
        finished = 1'b0;
        repeat (3) tick();
        check("rst_finished_ignored", 64'({proc2Dcache_command, empty}), 64'({2'd0, 1'b1}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
